ifetch_r32i: RTL
================

IFETCH_R32I -- requirements
Module: ifetch_r32i

Interface
REQ-001 Parameter dataW, default 32, SHALL set the data and address width.
REQ-002 Parameter Depth, default 2, SHALL set the number of instruction buffer entries (minimum 2).
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ProgAddr  input  dataW  SHALL carry the fetch address from the PC stage.
REQ-006 Flush  input  1  SHALL mean a branch was taken and buffered or in-flight instructions are stale.
REQ-007 FetchStall  output  1  SHALL tell the PC stage to hold ProgAddr; high = hold.
REQ-008 MemReq  output  1  SHALL be the instruction memory request.
REQ-009 MemAddr  output  dataW  SHALL be the request address.
REQ-010 MemAck  input  1  SHALL be the memory acknowledge; data is valid with it.
REQ-011 MemRData  input  dataW  SHALL be the returned instruction word.
REQ-012 Instr  output  dataW  SHALL be the head-of-buffer instruction.
REQ-013 InstrAddr  output  dataW  SHALL be the head-of-buffer instruction address.
REQ-014 InstrValid  output  1  SHALL indicate that the buffer is not empty.
REQ-015 InstrReady  input  1  SHALL mean decode accepts the head entry.
REQ-016 MisalignErr  output  1  SHALL be a sticky misaligned-fetch flag (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and DRAIN.
REQ-018 IDLE -> REQ SHALL occur when Flush=0 and the buffer count < Depth; MemReq=1 only in REQ; MemAddr SHALL be latched from ProgAddr on entry and held stable until ack.
REQ-019 In REQ with MemAck=1 and Flush=0, {MemAddr, MemRData} SHALL be pushed and the FSM SHALL go to IDLE.
REQ-020 FetchStall SHALL be 0 only in the cycle REQ, MemAck=1, Flush=0; the PC advances exactly once per accepted fetch.
REQ-021 A handshake SHALL pop the head entry when InstrValid=1 and InstrReady=1.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged.
REQ-023 At most one request SHALL be outstanding; no push SHALL occur with count = Depth.
REQ-024 Push-to-InstrValid latency SHALL be 1 cycle; minimum ProgAddr-to-InstrValid latency SHALL be 2 cycles with zero-wait memory.
REQ-025 Flush SHALL clear the buffer next edge and SHALL have priority over push and pop.
REQ-026 Flush in REQ with MemAck=0 SHALL go to DRAIN.
REQ-027 Flush in REQ with MemAck=1 SHALL discard the data and go to IDLE.
REQ-028 DRAIN SHALL hold MemReq=1 until MemAck, discard the data, then go to IDLE; Flush in DRAIN SHALL be absorbed.
REQ-029 Buffer pointers SHALL wrap modulo Depth.

Reset
REQ-030 Reset SHALL immediately force IDLE, an empty buffer, MemReq=0, MemAddr=0, InstrValid=0, Instr=0, InstrAddr=0, FetchStall=1 and MisalignErr=0.
REQ-031 Reset SHALL override any outstanding request; a late MemAck after reset SHALL be ignored while not in REQ or DRAIN.
REQ-032 The first request SHALL be issued in the first cycle after reset deasserts.

Configuration
REQ-033 With IFETCH_MISALIGN_CHECK_EN defined, ProgAddr[1:0] != 0 in IDLE SHALL set MisalignErr (cleared only by reset), block REQ entry and keep FetchStall=1 until Flush supplies an aligned address.
REQ-034 Without IFETCH_MISALIGN_CHECK_EN, MemAddr[1:0] SHALL be forced to 0 and MisalignErr SHALL be tied to 0.

Verification
REQ-035 Zero-wait memory, InstrReady=1, PC increments from 0: Instr/InstrAddr SHALL stream 0,4,8,...; first InstrValid at cycle 2 after reset.
REQ-036 InstrReady=0 for 5 cycles: count SHALL reach 2, MemReq SHALL stay 0, FetchStall=1; InstrReady=1 SHALL resume with no loss or duplication.
REQ-037 MemAck delayed 3 cycles with Flush in cycle 1 and ProgAddr=40: stale data SHALL be dropped (DRAIN); the next request SHALL use MemAddr=40 and only 40 SHALL appear at InstrAddr.
REQ-038 Flush, MemAck and InstrReady all asserted with 2 entries buffered: buffer SHALL be empty and no push SHALL occur.
REQ-039 Reset asserted mid-REQ: MemReq=0 and InstrValid=0 SHALL occur without waiting for a clock edge; the first post-reset request SHALL use the current ProgAddr.
REQ-040 ProgAddr=6 with IFETCH_MISALIGN_CHECK_EN defined: MisalignErr=1 and no MemReq SHALL occur; without the macro, MemAddr SHALL equal 4.

Source files
------------

// File: rtl/ifetch_r32i.sv
// ifetch_r32i: single-outstanding instruction fetch with a small FIFO.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned fetch addresses.
module ifetch_r32i #(
  parameter int dataW = 32,
  parameter int Depth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic             FetchStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemRData,
  output logic [dataW-1:0] Instr,
  output logic [dataW-1:0] InstrAddr,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic             MisalignErr
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] Full = CntW'(Depth);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state, nextState;

  logic [dataW-1:0] instrBuf [Depth];
  logic [dataW-1:0] addrBuf [Depth];
  logic [PtrW-1:0]  rdPtr, wrPtr;
  logic [CntW-1:0]  count;
  logic             push, pop, startReq, misaligned;
  logic [dataW-1:0] reqAddr;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misaligned = ProgAddr[1:0] != 2'b00;
  assign reqAddr = ProgAddr;

  // sticky misalign flag, only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) MisalignErr <= 1'b0;
    else if (state == IDLE && misaligned) MisalignErr <= 1'b1;
  end
`else
  logic unusedLowBits;
  assign unusedLowBits = ^ProgAddr[1:0];
  assign misaligned = 1'b0;
  assign reqAddr = {ProgAddr[dataW-1:2], 2'b00};
  assign MisalignErr = 1'b0;
`endif

  assign InstrValid = count != '0;
  assign pop = InstrValid && InstrReady && !Flush;
  assign startReq = (state == IDLE) && !Flush &&
                    (count < Full) && !misaligned;
  assign Instr = InstrValid ? instrBuf[rdPtr] : '0;
  assign InstrAddr = InstrValid ? addrBuf[rdPtr] : '0;

  // next state, memory request and PC hold
  always_comb begin
    nextState = state;
    push = 1'b0;
    FetchStall = 1'b1;
    MemReq = 1'b0;
    unique case (state)
      IDLE: if (startReq) nextState = REQ;
      REQ: begin
        MemReq = 1'b1;
        if (MemAck) begin
          nextState = IDLE;
          push = !Flush;
          FetchStall = Flush;
        end else if (Flush) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        MemReq = 1'b1;
        if (MemAck) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // state register and request address latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      MemAddr <= '0;
    end else begin
      state <= nextState;
      if (startReq) MemAddr <= reqAddr;
    end
  end

  // buffer pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (Flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= (wrPtr == LastPtr) ? '0 : wrPtr + 1'b1;
      if (pop) rdPtr <= (rdPtr == LastPtr) ? '0 : rdPtr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // buffer storage; outputs are gated by InstrValid so no reset needed
  always_ff @(posedge clock) begin
    if (push) begin
      instrBuf[wrPtr] <= MemRData;
      addrBuf[wrPtr] <= MemAddr;
    end
  end
endmodule
